// File: rtl/rom_loader.sv
// rom_loader: steers the data_io download byte stream into per-region SDRAM write ports, tracks ROM-loaded state and generates the core reset
//   clk_sys      system clock
//   reset        synchronous active-high reset (also resets the SDRAM controller, so its acks return to 0)
//   user_reset   OSD/button reset request, affects core_reset only
//   ioctl_*      data_io download interface (downl level, index, wr strobe level, addr, dout)
//   port_req     per-region request toggle, port_ack per-region ack toggle
//   port_we      per-region write enable (registered ioctl_downl)
//   port_a/ds/d  per-region word address, {hi,lo} byte selects, byte duplicated into both lanes
//   rom_loaded   ROM image complete
//   core_reset   reset to the game core, held RESET_HOLD cycles after rom_loaded rises
//   overrun      sticky, a byte was dropped because its region was still busy
module rom_loader #(
    parameter int REGIONS = 2,
    parameter int ADDR_W = 25,
    parameter logic [REGIONS*8-1:0] REGION_INDEX = {8'd0, 8'd0},
    parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {25'hA000, 25'h0},
    parameter logic [REGIONS*ADDR_W-1:0] REGION_SIZE = {25'h8000, 25'h1_0000},
    parameter logic [REGIONS*5-1:0] REGION_SPLIT = {5'd13, 5'd0},
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter int RESET_HOLD = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_reset,
    input  logic                  ioctl_downl,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [ADDR_W-1:0]     ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic [REGIONS-1:0]    port_req,
    input  logic [REGIONS-1:0]    port_ack,
    output logic [REGIONS-1:0]    port_we,
    output logic [REGIONS*23-1:0] port_a,
    output logic [REGIONS*2-1:0]  port_ds,
    output logic [REGIONS*16-1:0] port_d,
    output logic                  rom_loaded,
    output logic                  core_reset,
    output logic                  overrun
);
    localparam int HW = $clog2(RESET_HOLD + 2);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);

    logic wr_last, downl_last, got_rom, rl_nxt, strobe, rise, fall;
    logic [HW-1:0] hold, hold_nxt;
    logic [REGIONS-1:0] accept, drop;

    assign strobe = ioctl_downl & ioctl_wr & ~wr_last;
    assign rise = ioctl_downl & ~downl_last;
    assign fall = ~ioctl_downl & downl_last;

    for (genvar i = 0; i < REGIONS; i++) begin : g_region
        localparam int K = int'(REGION_SPLIT[i*5 +: 5]);
        localparam logic [ADDR_W-1:0] BASE = REGION_BASE[i*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] SIZE = REGION_SIZE[i*ADDR_W +: ADDR_W];
        logic [ADDR_W:0] diff;
        logic [ADDR_W-1:0] off;
        logic hit, idle, req;
        logic [22:0] a_nxt, a;
        logic [1:0] ds_nxt, ds;
        logic [15:0] d;
        // the extra top bit of diff is the borrow, i.e. ioctl_addr < BASE
        assign diff = {1'b0, ioctl_addr} - {1'b0, BASE};
        assign off = diff[ADDR_W-1:0];
        assign hit = ioctl_index == REGION_INDEX[i*8 +: 8] && !diff[ADDR_W] && (SIZE == '0 || off < SIZE);
        assign idle = req == port_ack[i];
        assign accept[i] = strobe & hit & idle;
        assign drop[i] = strobe & hit & ~idle;
        if (K == 0) begin : g_lin
            assign a_nxt = off[23:1];
            assign ds_nxt = {off[0], ~off[0]};
        end else begin : g_ilv
            // ROM select bits off[K+1:K]: K picks the byte lane, K+1 the 16-bit half of the 32-bit word
            assign a_nxt = {off[23:K+2], off[K-1:0], off[K+1]};
            assign ds_nxt = {off[K], ~off[K]};
        end
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                req <= 1'b0;
                a <= '0;
                ds <= '0;
                d <= '0;
            end else if (accept[i]) begin
                req <= ~req;
                a <= a_nxt;
                ds <= ds_nxt;
                d <= {2{ioctl_dout}};
            end
        end
        assign port_req[i] = req;
        assign port_a[i*23 +: 23] = a;
        assign port_ds[i*2 +: 2] = ds;
        assign port_d[i*16 +: 16] = d;
    end

    // core_reset is registered from the next-state values so it drops exactly RESET_HOLD clocks after rom_loaded rises
    always_comb begin
        rl_nxt = (fall & got_rom) ? 1'b1 : (rise & ioctl_index == ROM_INDEX) ? 1'b0 : rom_loaded;
        hold_nxt = (rl_nxt & ~rom_loaded) ? HOLD_LOAD : (hold != '0) ? hold - HW'(1) : hold;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_last <= 1'b0;
            downl_last <= 1'b0;
            port_we <= '0;
            overrun <= 1'b0;
            got_rom <= 1'b0;
            rom_loaded <= 1'b0;
            hold <= '0;
            core_reset <= 1'b1;
        end else begin
            wr_last <= ioctl_wr;
            downl_last <= ioctl_downl;
            port_we <= {REGIONS{ioctl_downl}};
            overrun <= (overrun & ~rise) | (|drop);
            got_rom <= (got_rom & ~rise) | ((|accept) & ioctl_index == ROM_INDEX);
            rom_loaded <= rl_nxt;
            hold <= hold_nxt;
            core_reset <= user_reset | ~rl_nxt | (hold_nxt != '0);
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench for rom_loader against a behavioural region/handshake model
module tb_rom_loader;
    localparam int R = 2;
    localparam int AW = 25;
    localparam int HOLD = 16;
    localparam int BASE [R] = '{0, 'hA000};
    localparam int SIZE [R] = '{'h10000, 'h8000};
    localparam int SPLIT [R] = '{0, 13};

    logic clk_sys = 0, reset = 1, user_reset = 0, ioctl_downl = 0, ioctl_wr = 0;
    logic [7:0] ioctl_index = 0, ioctl_dout = 0;
    logic [AW-1:0] ioctl_addr = 0;
    logic [R-1:0] port_ack = 0, port_req, port_we;
    logic [R*23-1:0] port_a;
    logic [R*2-1:0] port_ds;
    logic [R*16-1:0] port_d;
    logic rom_loaded, core_reset, overrun;

    rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
        .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .port_req(port_req), .port_ack(port_ack), .port_we(port_we),
        .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
        .rom_loaded(rom_loaded), .core_reset(core_reset), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0;
    logic [R-1:0] m_req = 0, hold_ack = 0;
    int m_a [R] = '{0, 0};
    int m_ds [R] = '{0, 0};
    int m_d [R] = '{0, 0};
    bit m_ovr = 0, m_rl = 0, m_got = 0;
    int lat [R] = '{3, 3};
    int cnt [R] = '{0, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM controller stand-in: answers each request after a random latency unless withheld
    initial forever begin
        @(posedge clk_sys);
        #2;
        for (int i = 0; i < R; i++) begin
            if (reset) begin
                port_ack[i] = 1'b0;
                cnt[i] = 0;
            end else if (port_req[i] != port_ack[i] && !hold_ack[i]) begin
                cnt[i]++;
                if (cnt[i] >= lat[i]) begin
                    port_ack[i] = port_req[i];
                    cnt[i] = 0;
                    lat[i] = int'($urandom_range(1, 4));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int map_a(int i, int off);
        int k = SPLIT[i];
        if (k == 0) return (off >> 1) & 'h7FFFFF;
        return (((off >> (k + 2)) << (k + 1)) | ((off & ((1 << k) - 1)) << 1) | ((off >> (k + 1)) & 1)) & 'h7FFFFF;
    endfunction

    function automatic int map_ds(int i, int off);
        int lane = (SPLIT[i] == 0) ? (off & 1) : ((off >> SPLIT[i]) & 1);
        return lane ? 2 : 1;
    endfunction

    function automatic int pick_addr();
        case ($urandom_range(0, 5))
            0: return int'($urandom_range(0, 'h1F));
            1: return 'h9FF8 + int'($urandom_range(0, 15));
            2: return 'hFFF8 + int'($urandom_range(0, 15));
            3: return 'h11FF8 + int'($urandom_range(0, 15));
            4: return int'($urandom_range(0, 'h1FFFF));
            default: return int'($urandom_range(0, 'h1FFFFFF));
        endcase
    endfunction

    task automatic check_ports(input string tag);
        for (int i = 0; i < R; i++) begin
            check({tag, "_req"}, 64'(port_req[i]), 64'(m_req[i]));
            check({tag, "_a"}, 64'(port_a[i*23 +: 23]), 64'(m_a[i]));
            check({tag, "_ds"}, 64'(port_ds[i*2 +: 2]), 64'(m_ds[i]));
            check({tag, "_d"}, 64'(port_d[i*16 +: 16]), 64'(m_d[i]));
        end
        check({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
    endtask

    task automatic wr_byte(input int addr, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_addr = AW'(addr);
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        for (int i = 0; i < R; i++) begin
            if (ioctl_downl && ioctl_index == 0 && addr >= BASE[i] && addr - BASE[i] < SIZE[i]) begin
                if (m_req[i] == port_ack[i]) begin
                    m_req[i] = ~m_req[i];
                    m_a[i] = map_a(i, addr - BASE[i]);
                    m_ds[i] = map_ds(i, addr - BASE[i]);
                    m_d[i] = (int'(d) << 8) | int'(d);
                    m_got = 1;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        @(posedge clk_sys);
        #1;
        check_ports("wr");
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && port_ack != m_req; k++) @(negedge clk_sys);
        check("ack_wait", 64'(port_ack), 64'(m_req));
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_downl = 1'b1;
        ioctl_index = idx;
        m_ovr = 0;
        m_got = 0;
        if (idx == 0) m_rl = 0;
        @(posedge clk_sys);
        #1;
        check("start_ovr", 64'(overrun), 64'(m_ovr));
        check("start_rl", 64'(rom_loaded), 64'(m_rl));
        check("start_cr", 64'(core_reset), 64'(!m_rl));
        check("start_we", 64'(port_we), 64'({R{ioctl_downl}}));
    endtask

    task automatic end_dl(input bit with_wr);
        bit rose;
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        if (with_wr) begin
            ioctl_addr = 0;
            ioctl_wr = 1'b1;
        end
        rose = !m_rl && m_got && ioctl_index == 0;
        if (rose) m_rl = 1;
        @(posedge clk_sys);
        #1;
        check("end_rl", 64'(rom_loaded), 64'(m_rl));
        check("end_we", 64'(port_we), 64'({R{ioctl_downl}}));
        check_ports("end");
        if (rose) begin
            check("cr_rise", 64'(core_reset), 64'(1));
            for (int k = 1; k <= HOLD + 1; k++) begin
                @(negedge clk_sys);
                ioctl_wr = 1'b0;
                @(posedge clk_sys);
                #1;
                check("cr_hold", 64'(core_reset), 64'(k < HOLD));
            end
        end else begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            check("cr_idle", 64'(core_reset), 64'(!m_rl));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        check_ports("rst");
        check("rst_we", 64'(port_we), 64'(0));
        check("rst_rl", 64'(rom_loaded), 64'(0));
        check("rst_cr", 64'(core_reset), 64'(1));
        @(negedge clk_sys);
        reset = 1'b0;

        start_dl(0);
        wr_byte(0, 8'h11);
        check("t1_a", 64'(port_a[22:0]), 64'(0));
        check("t1_ds0", 64'(port_ds[1:0]), 64'(2'b01));
        check("t1_d0", 64'(port_d[15:0]), 64'(16'h1111));
        wait_idle();
        wr_byte(1, 8'h22);
        check("t1_ds1", 64'(port_ds[1:0]), 64'(2'b10));
        check("t1_d1", 64'(port_d[15:0]), 64'(16'h2222));
        check("t1_r1", 64'(port_req[1]), 64'(0));
        wait_idle();

        wr_byte('hA000 + 'h6001, 8'h5A);
        check("t2_a", 64'(port_a[45:23]), 64'(23'h3));
        check("t2_ds", 64'(port_ds[3:2]), 64'(2'b10));
        wait_idle();

        hold_ack[0] = 1'b1;
        wr_byte(2, 8'h33);
        wr_byte(3, 8'h44);
        check("t3_ovr", 64'(overrun), 64'(1));
        hold_ack[0] = 1'b0;
        wait_idle();

        foreach (BASE[i]) begin
            wr_byte(BASE[i] + SIZE[i] - 1, 8'hE0);
            wait_idle();
            wr_byte(BASE[i] + SIZE[i], 8'hE1);
            wait_idle();
        end
        wr_byte('h9FFF, 8'hE2);
        wait_idle();
        end_dl(0);

        @(negedge clk_sys);
        user_reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check("ureset_on", 64'(core_reset), 64'(1));
        @(negedge clk_sys);
        user_reset = 1'b0;
        @(posedge clk_sys);
        #1;
        check("ureset_off", 64'(core_reset), 64'(0));

        start_dl(1);
        wr_byte('h10, 8'h77);
        end_dl(0);
        check("t6_rl", 64'(rom_loaded), 64'(1));

        start_dl(0);
        for (int b = 0; b < 5; b++) begin
            wr_byte(pick_addr(), 8'($urandom));
            repeat ($urandom_range(0, 4)) @(negedge clk_sys);
        end
        @(negedge clk_sys);
        reset = 1'b1;
        ioctl_downl = 1'b0;
        m_req = 0;
        m_a = '{0, 0};
        m_ds = '{0, 0};
        m_d = '{0, 0};
        m_ovr = 0;
        m_rl = 0;
        m_got = 0;
        @(posedge clk_sys);
        #1;
        check_ports("mid_rst");
        check("mid_rst_rl", 64'(rom_loaded), 64'(0));
        check("mid_rst_cr", 64'(core_reset), 64'(1));
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        for (int n = 0; n < 8; n++) begin
            logic [7:0] idx;
            idx = (n == 0 || $urandom_range(0, 3) != 0) ? 8'd0 : 8'd1;
            start_dl(idx);
            for (int b = 0; b < int'($urandom_range(8, 20)); b++) begin
                wr_byte(pick_addr(), 8'($urandom));
                repeat ($urandom_range(0, 5)) @(negedge clk_sys);
            end
            end_dl(n == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
